mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 34 +++
 rtl/mem_arb_starve_cnt.sv | 43 ++++
 rtl/mem_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the single-port memory arbiter.
//   state_t  : arbiter operating mode (RUN / DRAIN / LOAD)
//   owner_t  : which requester owns the read currently in flight
//   STARVE_MAX_DEFAULT : default limit of consecutive fetch denials
//   cntWidth : bit width needed to hold a counter value 0..maxVal
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int STARVE_MAX_DEFAULT = 4;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        LOAD  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    // Width of a counter that must reach maxVal. A zero-width counter is
    // not representable, so the result never drops below one bit.
    function automatic int cntWidth(input int maxVal);
        if (maxVal < 1) begin
            return 1;
        end
        return $clog2(maxVal + 1);
    endfunction

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// ---------------------------------------------------------------------------
// mem_arb_starve_cnt
// Saturating counter of consecutive instruction-fetch denials.
// Ports:
//   clk      : clock, state updates on rising edge
//   rst      : asynchronous active-high reset, clears the count
//   i_req    : fetch request present this cycle
//   i_gnt    : fetch request granted this cycle
//   o_cnt    : current number of consecutive denials (saturates)
// ---------------------------------------------------------------------------
module mem_arb_starve_cnt
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT,
    parameter int CNT_W      = cntWidth(STARVE_MAX)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_req,
    input  logic             i_gnt,
    output logic [CNT_W-1:0] o_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] r_cnt;

    // Count only unbroken runs of denials: a grant or a cycle without a
    // fetch request ends the run. Once the limit is reached the count holds
    // there so the arbiter keeps seeing "starved" until fetch wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!i_req || i_gnt) begin
            r_cnt <= '0;
        end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Arbitrates one single-port 32-bit memory between an instruction-fetch
// port, a data (LW/SW) port and a loader port used while the core is halted.
// Grants are single-cycle combinational pulses; a granted read returns its
// data one cycle later with the matching rvalid.
// Ports:
//   clk, rst                       : clock, async active-high reset
//   cpu_halted                     : core halted, hands memory to the loader
//   if_req/if_addr -> if_gnt/if_rvalid
//   d_req/d_we/d_addr/d_wdata -> d_gnt/d_rvalid
//   ld_req/ld_addr/ld_wdata -> ld_gnt
//   rdata                          : shared read data (mem_rdata pass-through)
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata : memory side
// ---------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_halted,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,

    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_wdata,
    output logic              ld_gnt,

    output logic [31:0]       rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int CNT_W = cntWidth(STARVE_MAX);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    state_t           r_state;
    owner_t           r_owner;
    logic [CNT_W-1:0] w_starveCnt;
    logic             w_starveWin;
    logic             w_ifGnt;
    logic             w_dGnt;
    logic             w_ldGnt;

    mem_arb_starve_cnt #(
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (CNT_W)
    ) u_starveCnt (
        .clk   (clk),
        .rst   (rst),
        .i_req (if_req),
        .i_gnt (w_ifGnt),
        .o_cnt (w_starveCnt)
    );

    // Fetch overrides the normal data-first priority once it has been
    // denied the maximum number of times in a row.
    assign w_starveWin = if_req && (w_starveCnt == CNT_MAX);

    // Grant decision. In RUN the data port normally wins over fetch, DRAIN
    // grants nothing so the last read can finish cleanly, and LOAD belongs
    // to the loader alone. Reset forces every grant low immediately so the
    // memory strobe cannot fire while the arbiter is being reset.
    always_comb begin
        w_ifGnt = 1'b0;
        w_dGnt  = 1'b0;
        w_ldGnt = 1'b0;
        if (!rst) begin
            case (r_state)
                RUN: begin
                    w_dGnt  = d_req && !w_starveWin;
                    w_ifGnt = if_req && !w_dGnt;
                end
                LOAD: begin
                    w_ldGnt = ld_req;
                end
                default: begin
                    w_ifGnt = 1'b0;
                    w_dGnt  = 1'b0;
                    w_ldGnt = 1'b0;
                end
            endcase
        end
    end

    // Memory side mux. Addresses and data are driven only while a grant is
    // active so the bus sits at zero when idle, including during reset.
    always_comb begin
        mem_en    = w_ifGnt || w_dGnt || w_ldGnt;
        mem_we    = (w_dGnt && d_we) || w_ldGnt;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_dGnt) begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else if (w_ifGnt) begin
            mem_addr  = if_addr;
        end else if (w_ldGnt) begin
            mem_addr  = ld_addr;
            mem_wdata = ld_wdata;
        end
    end

    // Mode sequencing and read-owner tracking. The owner records who
    // issued the read granted this cycle so next cycle's rvalid can be
    // steered to the right port; writes leave no owner. DRAIN is a fixed
    // single cycle that lets a read granted on the last RUN cycle return
    // before the loader takes over.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RUN;
            r_owner <= OWN_NONE;
        end else begin
            if (w_ifGnt) begin
                r_owner <= OWN_IF;
            end else if (w_dGnt && !d_we) begin
                r_owner <= OWN_D;
            end else begin
                r_owner <= OWN_NONE;
            end

            case (r_state)
                RUN: begin
                    if (cpu_halted) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    r_state <= LOAD;
                end
                LOAD: begin
                    if (!cpu_halted) begin
                        r_state <= RUN;
                    end
                end
                default: begin
                    r_state <= RUN;
                end
            endcase
        end
    end

    assign if_gnt    = w_ifGnt;
    assign d_gnt     = w_dGnt;
    assign ld_gnt    = w_ldGnt;
    assign if_rvalid = (r_owner == OWN_IF);
    assign d_rvalid  = (r_owner == OWN_D);
    assign rdata     = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter with a memory behind it, a cycle-level
// reference model of the arbitration rules and literal spot checks.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int ADDR_W = 10;
    localparam int SMAX   = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              cpu_halted;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic              ld_req;
    logic [ADDR_W-1:0] ld_addr;
    logic [31:0]       ld_wdata;
    logic              ld_gnt;
    logic [31:0]       rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    int nVec = 0;
    int nMis = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W     (ADDR_W),
        .STARVE_MAX (SMAX)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_halted (cpu_halted),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_gnt      (d_gnt),
        .d_rvalid   (d_rvalid),
        .ld_req     (ld_req),
        .ld_addr    (ld_addr),
        .ld_wdata   (ld_wdata),
        .ld_gnt     (ld_gnt),
        .rdata      (rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Synchronous 1024 x 32 memory with one-cycle read latency.
    logic [31:0] memArr [1024];
    logic [31:0] shadow [1024];

    always @(posedge clk) begin
        if (mem_en && !mem_we) mem_rdata <= memArr[mem_addr];
        if (mem_en && mem_we)  memArr[mem_addr] <= mem_wdata;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 = running, 1 = draining, 2 = loading.
    int          mMode   = 0;
    int          mStarve = 0;
    bit          mPendIf = 0;
    bit          mPendD  = 0;
    logic [31:0] mPendData = '0;
    bit          eIf, eD, eLd, eWe;
    logic [ADDR_W-1:0] eAddr;
    logic [31:0] eData;

    // Compare the DUT against the model every falling edge, then advance
    // the model by one cycle.
    always @(negedge clk) begin
        if (rst) begin
            checkOutput("rst_if_gnt",    if_gnt,    0);
            checkOutput("rst_d_gnt",     d_gnt,     0);
            checkOutput("rst_ld_gnt",    ld_gnt,    0);
            checkOutput("rst_if_rvalid", if_rvalid, 0);
            checkOutput("rst_d_rvalid",  d_rvalid,  0);
            checkOutput("rst_mem_en",    mem_en,    0);
            checkOutput("rst_mem_we",    mem_we,    0);
            checkOutput("rst_mem_addr",  mem_addr,  0);
            checkOutput("rst_mem_wdata", mem_wdata, 0);
            mMode = 0; mStarve = 0; mPendIf = 0; mPendD = 0;
        end else begin
            eIf = 0; eD = 0; eLd = 0;
            if (mMode == 0) begin
                if (if_req && mStarve >= SMAX) eIf = 1;
                else if (d_req)                eD  = 1;
                else if (if_req)               eIf = 1;
            end else if (mMode == 2) begin
                eLd = ld_req;
            end
            eWe   = (eD && d_we) || eLd;
            eAddr = eD ? d_addr : (eIf ? if_addr : ld_addr);
            eData = eD ? d_wdata : ld_wdata;

            checkOutput("m_if_gnt",    if_gnt,    eIf);
            checkOutput("m_d_gnt",     d_gnt,     eD);
            checkOutput("m_ld_gnt",    ld_gnt,    eLd);
            checkOutput("m_mem_en",    mem_en,    eIf || eD || eLd);
            checkOutput("m_mem_we",    mem_we,    eWe);
            checkOutput("m_if_rvalid", if_rvalid, mPendIf);
            checkOutput("m_d_rvalid",  d_rvalid,  mPendD);
            if (eIf || eD || eLd) checkOutput("m_mem_addr", mem_addr, eAddr);
            if (eWe)              checkOutput("m_mem_wdata", mem_wdata, eData);
            if (mPendIf || mPendD) checkOutput("m_rdata", rdata, mPendData);

            mPendIf = eIf;
            mPendD  = eD && !d_we;
            if (eIf || (eD && !d_we)) mPendData = shadow[eAddr];
            if (eWe) shadow[eAddr] = eData;

            if (if_req && !eIf) mStarve = (mStarve < SMAX) ? mStarve + 1 : SMAX;
            else                mStarve = 0;

            if (mMode == 0 && cpu_halted)       mMode = 1;
            else if (mMode == 1)                mMode = 2;
            else if (mMode == 2 && !cpu_halted) mMode = 0;
        end
    end

    // Drive one cycle of requests shortly after the rising edge.
    task automatic applyStimulus(
        input bit ifR, input logic [ADDR_W-1:0] ifA,
        input bit dR, input bit dW, input logic [ADDR_W-1:0] dA, input logic [31:0] dWd,
        input bit ldR, input logic [ADDR_W-1:0] ldA, input logic [31:0] ldWd,
        input bit halt);
        @(posedge clk);
        #1;
        if_req = ifR; if_addr = ifA;
        d_req = dR; d_we = dW; d_addr = dA; d_wdata = dWd;
        ld_req = ldR; ld_addr = ldA; ld_wdata = ldWd;
        cpu_halted = halt;
    endtask

    task automatic idle();
        applyStimulus(0, '0, 0, 0, '0, '0, 0, '0, '0, 0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            memArr[i] = 32'h1000_0000 + i;
        end
        memArr[5] = 32'h0000_00A5;
        for (int i = 0; i < 1024; i++) shadow[i] = memArr[i];

        rst = 1; cpu_halted = 0; mem_rdata = '0;
        if_req = 0; if_addr = '0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        ld_req = 0; ld_addr = '0; ld_wdata = '0;

        repeat (3) @(posedge clk);
        #2;
        checkOutput("lit_rst_mem_en", mem_en, 0);

        // Lone fetch of word 5 right after reset release.
        applyStimulus(1, 10'd5, 0, 0, '0, '0, 0, '0, '0, 0);
        rst = 0;
        #1;
        checkOutput("lit_first_if_gnt", if_gnt, 1);
        checkOutput("lit_first_mem_addr", mem_addr, 10'd5);
        idle();
        #1;
        checkOutput("lit_first_if_rvalid", if_rvalid, 1);
        checkOutput("lit_first_rdata", rdata, 32'h0000_00A5);

        // Data and fetch compete for six cycles; fetch wins only on the fifth.
        for (int c = 0; c < 6; c++) begin
            applyStimulus(1, 10'h010, 1, 0, 10'h020, '0, 0, '0, '0, 0);
            #1;
            checkOutput($sformatf("lit_starve_d_gnt_c%0d", c), d_gnt, (c == 4) ? 0 : 1);
            checkOutput($sformatf("lit_starve_if_gnt_c%0d", c), if_gnt, (c == 4) ? 1 : 0);
        end
        idle();

        // Store to the top word, then read it back.
        applyStimulus(0, '0, 1, 1, 10'h3FF, 32'hDEADBEEF, 0, '0, '0, 0);
        #1;
        checkOutput("lit_sw_mem_we", mem_we, 1);
        checkOutput("lit_sw_mem_addr", mem_addr, 10'h3FF);
        checkOutput("lit_sw_mem_wdata", mem_wdata, 32'hDEADBEEF);
        applyStimulus(0, '0, 1, 0, 10'h3FF, '0, 0, '0, '0, 0);
        #1;
        checkOutput("lit_sw_no_rvalid", d_rvalid, 0);
        checkOutput("lit_lw_mem_we", mem_we, 0);
        idle();
        #1;
        checkOutput("lit_lw_rdata", rdata, 32'hDEADBEEF);

        // Loader is ignored while running.
        applyStimulus(0, '0, 0, 0, '0, '0, 1, 10'h040, 32'h1234_5678, 0);
        #1;
        checkOutput("lit_ld_in_run", ld_gnt, 0);

        // Fetch granted, then halt: response completes, one drain cycle, load.
        applyStimulus(1, 10'd7, 0, 0, '0, '0, 1, 10'h040, 32'h1234_5678, 0);
        #1;
        checkOutput("lit_halt_if_gnt", if_gnt, 1);
        applyStimulus(0, '0, 0, 0, '0, '0, 1, 10'h040, 32'h1234_5678, 1);
        #1;
        checkOutput("lit_halt_if_rvalid", if_rvalid, 1);
        checkOutput("lit_halt_rdata", rdata, 32'h1000_0007);
        checkOutput("lit_halt_ld_gnt", ld_gnt, 0);
        applyStimulus(1, 10'd8, 0, 0, '0, '0, 1, 10'h040, 32'h1234_5678, 1);
        #1;
        checkOutput("lit_drain_ld_gnt", ld_gnt, 0);
        checkOutput("lit_drain_if_gnt", if_gnt, 0);
        applyStimulus(1, 10'd8, 0, 0, '0, '0, 1, 10'h040, 32'h1234_5678, 1);
        #1;
        checkOutput("lit_load_ld_gnt", ld_gnt, 1);
        checkOutput("lit_load_if_gnt", if_gnt, 0);
        applyStimulus(1, 10'd8, 0, 0, '0, '0, 1, 10'h041, 32'hCAFE_F00D, 1);
        #1;
        checkOutput("lit_load2_mem_addr", mem_addr, 10'h041);
        applyStimulus(1, 10'd8, 0, 0, '0, '0, 0, '0, '0, 0);
        #1;
        checkOutput("lit_unhalt_if_gnt", if_gnt, 0);
        applyStimulus(1, 10'd8, 0, 0, '0, '0, 0, '0, '0, 0);
        #1;
        checkOutput("lit_run_again_if_gnt", if_gnt, 1);
        applyStimulus(0, '0, 1, 0, 10'h041, '0, 0, '0, '0, 0);
        idle();
        #1;
        checkOutput("lit_loaded_rdata", rdata, 32'hCAFE_F00D);

        // Reset lands while a fetch response is pending.
        applyStimulus(1, 10'd5, 0, 0, '0, '0, 0, '0, '0, 0);
        #1;
        checkOutput("lit_pre_rst_if_gnt", if_gnt, 1);
        @(posedge clk);
        #1;
        rst = 1;
        #1;
        checkOutput("lit_async_rst_rvalid", if_rvalid, 0);
        checkOutput("lit_async_rst_if_gnt", if_gnt, 0);
        checkOutput("lit_async_rst_mem_en", mem_en, 0);
        repeat (2) @(posedge clk);
        idle();
        rst = 0;
        repeat (3) idle();

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
